// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit block as sixteen 32-bit words, then streams W[0..63].
// A 16-word sliding window holds W[t..t+15]. Each output handshake shifts the
// window by one word and appends the next schedule word.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both 1. A producer holding valid high keeps its data
// stable until that edge. ready never depends combinationally on the valid of
// the same port, and out_* never depends on in_valid.
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_index,
    output logic        out_last
);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]  state;
    logic [3:0]  load_cnt;
    logic [5:0]  emit_cnt;
    logic [31:0] w [16];

    logic        load_fire;
    logic        emit_fire;
    logic        win_shift;
    logic [31:0] w_next;
    logic [31:0] w_in;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Handshake decode, next schedule word and the word fed into the window.
    always_comb begin
        in_ready  = (state == ST_LOAD);
        out_valid = (state == ST_EMIT);
        out_word  = (state == ST_EMIT) ? w[0] : 32'd0;
        out_index = emit_cnt;
        out_last  = (state == ST_EMIT) && (emit_cnt == 6'd63);
        load_fire = (state == ST_LOAD) && in_valid;
        emit_fire = (state == ST_EMIT) && out_ready;
        win_shift = load_fire || emit_fire;
        // Words produced after t = 47 are never presented; the same update
        // runs anyway to keep the control trivial.
        w_next    = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
        w_in      = (state == ST_LOAD) ? in_word : w_next;
    end

    // Sliding window: shift toward w[0] and append at w[15] on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= 32'd0;
            end
        end else if (win_shift) begin
            for (int i = 0; i < 15; i++) begin
                w[i] <= w[i + 1];
            end
            w[15] <= w_in;
        end
    end

    // LOAD/EMIT sequencing with the load and emit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOAD;
            load_cnt <= 4'd0;
            emit_cnt <= 6'd0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        if (load_cnt == 4'd15) begin
                            state    <= ST_EMIT;
                            load_cnt <= 4'd0;
                            emit_cnt <= 6'd0;
                        end else begin
                            load_cnt <= load_cnt + 4'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (emit_fire) begin
                        if (emit_cnt == 6'd63) begin
                            state    <= ST_LOAD;
                            emit_cnt <= 6'd0;
                        end else begin
                            emit_cnt <= emit_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule. Inputs change on the falling edge,
// outputs are sampled on the falling edge, handshakes land on the rising edge.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_index;
    logic        out_last;

    int          n_pass;
    int          n_total;
    int          cyc_cnt;
    int          first_cyc;
    logic [31:0] blk [16];
    logic [31:0] got [64];
    logic [31:0] exp_q [$];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_index (out_index),
        .out_last  (out_last)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Hard time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule from the textbook recurrence, pushed into exp_q.
    task automatic build_exp();
        logic [31:0] ws [64];
        logic [31:0] s0;
        logic [31:0] s1;
        exp_q.delete();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                ws[t] = blk[t];
            end else begin
                s0 = rotr(ws[t-15], 7) ^ rotr(ws[t-15], 18) ^ (ws[t-15] >> 3);
                s1 = rotr(ws[t-2], 17) ^ rotr(ws[t-2], 19) ^ (ws[t-2] >> 10);
                ws[t] = s1 + ws[t-7] + s0 + ws[t-16];
            end
            exp_q.push_back(ws[t]);
        end
    endtask

    task automatic pulse_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver: present blk[0..n-1], optionally with idle gaps.
    task automatic load_block(input bit gaps, input int n);
        int wc;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_word  = $urandom;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_word  = blk[i];
            wc = 0;
            while (!in_ready && wc < 200) begin
                @(negedge clk);
                wc++;
            end
            chk("load_ready", 32'(in_ready), 32'd1);
            chk("load_no_out", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard drain: take n words, optionally with random stalls.
    task automatic drain(input bit stall, input int n);
        int wc;
        for (int t = 0; t < n; t++) begin
            wc = 0;
            while (!out_valid && wc < 200) begin
                @(negedge clk);
                wc++;
            end
            if (t == 0) first_cyc = cyc_cnt;
            chk("out_valid", 32'(out_valid), 32'd1);
            if (stall) begin
                out_ready = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_word", out_word, exp_q[0]);
                    chk("stall_index", 32'(out_index), 32'(t));
                end
            end
            chk("word", out_word, exp_q[0]);
            chk("index", 32'(out_index), 32'(t));
            chk("last", 32'(out_last), 32'(t == 63));
            chk("in_ready_emit", 32'(in_ready), 32'd0);
            got[t] = out_word;
            out_ready = 1'b1;
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        first_cyc = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        // "abc" block, no backpressure
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_exp();
        load_block(1'b0, 16);
        chk("abc_latency", 32'(out_valid), 32'd1);
        drain(1'b0, 64);
        chk("abc_span", 32'(cyc_cnt - first_cyc), 32'd64);
        chk("abc_ready_back", 32'(in_ready), 32'd1);
        chk("abc_valid_off", 32'(out_valid), 32'd0);
        chk("abc_w0", got[0], 32'h61626380);
        chk("abc_w15", got[15], 32'h00000018);
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000F0000);

        // Single-bit block
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0] = 32'h00000001;
        build_exp();
        load_block(1'b0, 16);
        drain(1'b0, 64);
        chk("bit_w16", got[16], 32'h00000001);
        chk("bit_w17", got[17], 32'h00000000);
        chk("bit_w18", got[18], 32'h0000A000);

        // All-zero block
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        build_exp();
        load_block(1'b0, 16);
        drain(1'b0, 64);
        chk("zero_w63", got[63], 32'd0);
        chk("zero_ready_back", 32'(in_ready), 32'd1);

        // Random block, input gaps and output stalls
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_exp();
        load_block(1'b1, 16);
        drain(1'b1, 64);
        chk("rnd_ready_back", 32'(in_ready), 32'd1);

        // Reset mid-load, then a fresh "abc" block
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(1'b0, 10);
        pulse_reset();
        chk("abortld_in_ready", 32'(in_ready), 32'd1);
        chk("abortld_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_exp();
        load_block(1'b0, 16);
        drain(1'b0, 64);
        chk("abortld_w17", got[17], 32'h000F0000);

        // Reset while index 30 is presented
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_exp();
        load_block(1'b0, 16);
        drain(1'b0, 30);
        chk("abortem_at30", 32'(out_index), 32'd30);
        pulse_reset();
        chk("abortem_out_valid", 32'(out_valid), 32'd0);
        chk("abortem_in_ready", 32'(in_ready), 32'd1);
        chk("abortem_out_index", 32'(out_index), 32'd0);
        chk("abortem_out_word", out_word, 32'd0);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_exp();
        load_block(1'b1, 16);
        drain(1'b1, 64);
        chk("abortem_ready_back", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
